// File: rtl/affine_interp_tap4_filter_if.sv
// Stream bundle for the 4-tap affine interpolation filter:
// sample input stream, filtered output stream and row error pulse.
interface affine_interp_tap4_filter_if #(
    parameter int BITDEPTH = 10
);
    logic                in_valid;
    logic                in_ready;
    logic [BITDEPTH-1:0] in_sample;
    logic [1:0]          in_frac;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [BITDEPTH-1:0] out_sample;
    logic                out_last;
    logic                row_err;

    modport master (
        output in_valid, in_sample, in_frac, in_last, out_ready,
        input  in_ready, out_valid, out_sample, out_last, row_err
    );

    modport slave (
        input  in_valid, in_sample, in_frac, in_last, out_ready,
        output in_ready, out_valid, out_sample, out_last, row_err
    );
endinterface

// File: rtl/affine_interp_tap4_filter.sv
// Streaming 4-tap horizontal interpolation filter: window fill FSM, shift-add
// coefficient products, then round/normalise/clip. Whole pipeline stalls on one enable.
module affine_interp_tap4_filter #(
    parameter int BITDEPTH = 10,
    parameter int SHIFT    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    affine_interp_tap4_filter_if.slave bus
);
    localparam int PW = BITDEPTH + 8;
    localparam int SW = BITDEPTH + 10;
    localparam logic signed [SW-1:0] RND  = SW'(1 << (SHIFT - 1));
    localparam logic signed [SW-1:0] MAXV = SW'((1 << BITDEPTH) - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_cnt, w_cnt_nxt;
    logic [1:0]            r_frac;
    logic [BITDEPTH-1:0]   r_win [4];
    logic                  r_w_vld, r_w_last;
    logic signed [PW-1:0]  r_p [4];
    logic                  r_a_vld, r_a_last;
    logic                  r_out_vld, r_out_last;
    logic [BITDEPTH-1:0]   r_out;
    logic                  r_err;

    logic                  w_adv, w_acc, w_issue, w_err_nxt, w_latch_frac;
    logic signed [SW-1:0]  w_sum, w_shr;
    logic [BITDEPTH-1:0]   w_clip;

    // Coefficient product for one tap, built from shifts and adds only.
    function automatic logic signed [PW-1:0] f_prod(input logic [BITDEPTH-1:0] s,
                                                    input logic [1:0] frac,
                                                    input logic [1:0] tap);
        logic signed [PW-1:0] x, m2, m4, m16, m36, m54, m64, r;
        x   = $signed({8'b0, s});
        m2  = x <<< 1;
        m4  = x <<< 2;
        m16 = x <<< 4;
        m36 = (x <<< 5) + m4;
        m64 = x <<< 6;
        m54 = m64 - (x <<< 3) - m2;
        r   = '0;
        case (tap)
            2'd0: case (frac)
                2'd1, 2'd2: r = -m4;
                2'd3:       r = -m2;
                default:    r = '0;
            endcase
            2'd1: case (frac)
                2'd0:    r = m64;
                2'd1:    r = m54;
                2'd2:    r = m36;
                default: r = m16;
            endcase
            2'd2: case (frac)
                2'd0:    r = '0;
                2'd1:    r = m16;
                2'd2:    r = m36;
                default: r = m54;
            endcase
            default: case (frac)
                2'd0:    r = '0;
                2'd1:    r = -m2;
                default: r = -m4;
            endcase
        endcase
        return r;
    endfunction

    assign w_adv        = !(r_out_vld && !bus.out_ready);
    assign w_acc        = bus.in_valid && w_adv;
    assign bus.in_ready = w_adv;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_issue      = 1'b0;
        w_err_nxt    = 1'b0;
        w_latch_frac = 1'b0;
        case (r_state)
            S_IDLE: if (w_acc) begin
                w_latch_frac = 1'b1;
                if (bus.in_last) begin
                    w_err_nxt = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt   = 3'd1;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: if (w_acc) begin
                if (r_cnt == 3'd3) begin
                    w_issue     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = bus.in_last ? S_IDLE : S_RUN;
                end else if (bus.in_last) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_RUN: if (w_acc) begin
                w_issue = 1'b1;
                if (bus.in_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Window stage: r_w_vld marks that the just-shifted window forms a full tap set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned t = 0; t < 4; t++) r_win[t] <= '0;
            r_frac   <= '0;
            r_w_vld  <= 1'b0;
            r_w_last <= 1'b0;
        end else if (w_adv) begin
            if (w_acc) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= r_win[3];
                r_win[3] <= bus.in_sample;
            end
            if (w_latch_frac) r_frac <= bus.in_frac;
            r_w_vld  <= w_issue;
            r_w_last <= w_issue && bus.in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned t = 0; t < 4; t++) r_p[t] <= '0;
            r_a_vld  <= 1'b0;
            r_a_last <= 1'b0;
        end else if (w_adv) begin
            for (int unsigned t = 0; t < 4; t++) r_p[t] <= f_prod(r_win[t], r_frac, 2'(t));
            r_a_vld  <= r_w_vld;
            r_a_last <= r_w_last;
        end
    end

    assign w_sum = SW'(r_p[0]) + SW'(r_p[1]) + SW'(r_p[2]) + SW'(r_p[3]) + RND;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        w_clip = w_shr[BITDEPTH-1:0];
        if (w_shr < 0)         w_clip = '0;
        else if (w_shr > MAXV) w_clip = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_out      <= '0;
        end else if (w_adv) begin
            r_out_vld  <= r_a_vld;
            r_out_last <= r_a_vld && r_a_last;
            if (r_a_vld) r_out <= w_clip;
        end
    end

    assign bus.out_valid  = r_out_vld;
    assign bus.out_last   = r_out_last;
    assign bus.out_sample = r_out;
    assign bus.row_err    = r_err;
endmodule

// File: tb/tb_affine_interp_tap4_filter.sv
// Directed bench for affine_interp_tap4_filter: table of rows with hand-computed
// outputs, plus backpressure and mid-row reset sequences.
module tb_affine_interp_tap4_filter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    affine_interp_tap4_filter_if #(.BITDEPTH(10)) bus ();

    affine_interp_tap4_filter #(.BITDEPTH(10), .SHIFT(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]       frac;
        logic [3:0]       len;
        logic [1:0]       nerr;
        logic [2:0]       nout;
        logic [7:0][9:0]  s;
        logic [4:0][9:0]  e;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    int acc_cyc  = 0;
    logic [9:0] q_s [$];
    logic       q_l [$];
    int         q_c [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                q_s.push_back(bus.out_sample);
                q_l.push_back(bus.out_last);
                q_c.push_back(cyc);
            end
            if (bus.row_err) err_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send(input logic [9:0] s, input logic [1:0] f, input logic l);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sample = s;
        bus.in_frac   = f;
        bus.in_last   = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        acc_cyc = cyc;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    function automatic vec_t mk(int f, int len, int nerr, int nout,
                                int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7,
                                int e0, int e1, int e2, int e3, int e4);
        vec_t v;
        v.frac = 2'(f);   v.len = 4'(len);  v.nerr = 2'(nerr); v.nout = 3'(nout);
        v.s[0] = 10'(a0); v.s[1] = 10'(a1); v.s[2] = 10'(a2); v.s[3] = 10'(a3);
        v.s[4] = 10'(a4); v.s[5] = 10'(a5); v.s[6] = 10'(a6); v.s[7] = 10'(a7);
        v.e[0] = 10'(e0); v.e[1] = 10'(e1); v.e[2] = 10'(e2); v.e[3] = 10'(e3);
        v.e[4] = 10'(e4);
        return v;
    endfunction

    task automatic clear_obs();
        q_s.delete();
        q_l.delete();
        q_c.delete();
        err_cnt = 0;
    endtask

    task automatic stall_proc();
        int n;
        logic [9:0] hs;
        logic       hl;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("bp_wait_valid", 0, 1);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        hs = bus.out_sample;
        hl = bus.out_last;
        chk("bp_valid_held", int'(bus.out_valid), 1);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        repeat (2) begin
            @(negedge clk);
            chk("bp_sample_stable", int'(bus.out_sample), int'(hs));
            chk("bp_last_stable", int'(bus.out_last), int'(hl));
            chk("bp_valid_held", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
    endtask

    initial begin
        int acc4;
        tbl[0] = mk(0, 5, 0, 2,   10, 20, 30, 40, 50, 0, 0, 0,   20, 30, 0, 0, 0);
        tbl[1] = mk(1, 4, 0, 1,   0, 0, 1023, 1023, 0, 0, 0, 0,  224, 0, 0, 0, 0);
        tbl[2] = mk(2, 6, 0, 3,   100, 100, 100, 100, 100, 100, 0, 0, 100, 100, 100, 0, 0);
        tbl[3] = mk(2, 4, 0, 1,   1023, 0, 0, 1023, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[4] = mk(2, 4, 0, 1,   0, 1023, 1023, 0, 0, 0, 0, 0,  1023, 0, 0, 0, 0);
        tbl[5] = mk(1, 3, 1, 0,   5, 6, 7, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0);
        tbl[6] = mk(3, 4, 0, 1,   100, 200, 300, 400, 0, 0, 0, 0, 275, 0, 0, 0, 0);
        tbl[7] = mk(1, 1, 1, 0,   7, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sample = '0; bus.in_frac = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sample", int'(bus.out_sample), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_row_err", int'(bus.row_err), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // in_frac is inverted after the first sample; the latched phase must win.
        for (int i = 0; i < NV; i++) begin
            clear_obs();
            acc4 = -1;
            for (int j = 0; j < int'(tbl[i].len); j++) begin
                send(tbl[i].s[j], (j == 0) ? tbl[i].frac : ~tbl[i].frac,
                     j == int'(tbl[i].len) - 1);
                if (j == 3) acc4 = acc_cyc;
            end
            repeat (8) @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), q_s.size(), int'(tbl[i].nout));
            for (int k = 0; k < int'(tbl[i].nout) && k < q_s.size(); k++) begin
                chk($sformatf("v%0d_out%0d", i, k), int'(q_s[k]), int'(tbl[i].e[k]));
                chk($sformatf("v%0d_last%0d", i, k), int'(q_l[k]),
                    (k == int'(tbl[i].nout) - 1) ? 1 : 0);
            end
            chk($sformatf("v%0d_row_err", i), err_cnt, int'(tbl[i].nerr));
            if (q_c.size() > 0) chk($sformatf("v%0d_latency", i), q_c[0] - acc4, 2);
        end

        // Backpressure: frac3 ramp 0..700, outputs a+175 for window start a.
        clear_obs();
        fork
            begin
                for (int j = 0; j < 8; j++)
                    send(10'(j * 100), (j == 0) ? 2'd3 : 2'd0, j == 7);
            end
            stall_proc();
        join
        repeat (10) @(posedge clk);
        #1;
        chk("bp_count", q_s.size(), 5);
        for (int k = 0; k < 5 && k < q_s.size(); k++) begin
            chk($sformatf("bp_out%0d", k), int'(q_s[k]), 175 + 100 * k);
            chk($sformatf("bp_last%0d", k), int'(q_l[k]), (k == 4) ? 1 : 0);
        end
        chk("bp_row_err", err_cnt, 0);

        // Reset with one output in flight and a partial row in the window.
        send(10'd10, 2'd0, 1'b0);
        send(10'd20, 2'd0, 1'b0);
        send(10'd30, 2'd0, 1'b0);
        send(10'd40, 2'd0, 1'b1);
        send(10'd1, 2'd1, 1'b0);
        send(10'd2, 2'd1, 1'b0);
        chk("pre_reset_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_out_sample", int'(bus.out_sample), 0);
        chk("mid_rst_out_last", int'(bus.out_last), 0);
        chk("mid_rst_row_err", int'(bus.row_err), 0);
        @(posedge clk);
        #1;
        clear_obs();
        send(10'd5, 2'd0, 1'b0);
        send(10'd6, 2'd0, 1'b0);
        send(10'd7, 2'd0, 1'b0);
        send(10'd8, 2'd0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_count", q_s.size(), 1);
        if (q_s.size() > 0) begin
            chk("post_rst_out", int'(q_s[0]), 6);
            chk("post_rst_last", int'(q_l[0]), 1);
        end
        chk("post_rst_row_err", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
